// File: rtl/program_loader.sv
// Instruction store for the 2-bit CPU with a valid/ready program-load port.
// Holds the CPU in reset until a full DEPTH-word program has been written.
module program_loader #(
    parameter int INSTR_WIDTH = 2,
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = 2
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   load_start,
    input  logic                   in_valid,
    input  logic [INSTR_WIDTH-1:0] in_data,
    output logic                   in_ready,
    input  logic [ADDR_WIDTH-1:0]  rd_addr,
    output logic [INSTR_WIDTH-1:0] rd_data,
    output logic                   cpu_reset,
    output logic                   load_done,
    output logic [ADDR_WIDTH:0]    word_count
);

    // One-hot so every control output is a single flop bit (glitch-free).
    typedef enum logic [2:0] {
        IDLE = 3'b001,
        LOAD = 3'b010,
        RUN  = 3'b100
    } state_e;

    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]     word_count_q, word_count_d;
    logic [INSTR_WIDTH-1:0]  mem_q [DEPTH];
    logic [INSTR_WIDTH-1:0]  mem_d [DEPTH];
    logic                    accept;

    // load_start wins over a simultaneous word; that word is dropped.
    assign accept = (state_q == LOAD) && in_valid && !load_start;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            word_count_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            word_count_q <= word_count_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        word_count_d = word_count_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
        if (load_start) begin
            state_d      = LOAD;
            wr_ptr_d     = '0;
            word_count_d = '0;
        end else if (accept) begin
            mem_d[wr_ptr_q] = in_data;
            wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
            word_count_d    = word_count_q + (ADDR_WIDTH+1)'(1);
            if (word_count_q == LAST_CNT) state_d = RUN;
        end
    end

    always_comb begin
        in_ready  = 1'b0;
        cpu_reset = 1'b1;
        load_done = 1'b0;
        case (state_q)
            LOAD:    in_ready = 1'b1;
            RUN: begin
                cpu_reset = 1'b0;
                load_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign word_count = word_count_q;
    assign rd_data    = mem_q[rd_addr];

endmodule

// File: tb/tb_program_loader.sv
// Directed plus randomized bench for program_loader against a
// phase/count-level model of the loader.
module tb_program_loader;
    localparam int IW = 2;
    localparam int D  = 4;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          clk_en = 1'b0;
    logic          reset_n;
    logic          load_start, in_valid;
    logic [IW-1:0] in_data;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [IW-1:0] rd_data;
    logic          cpu_reset, load_done;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;

    // Model: phase 0=idle 1=loading 2=running; cnt = words taken this load.
    logic [IW-1:0] m_mem [D];
    int            m_cnt;
    int            m_phase;

    always #10 if (clk_en) clk = ~clk;

    program_loader #(.INSTR_WIDTH(IW), .DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n), .load_start(load_start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .rd_addr(rd_addr), .rd_data(rd_data), .cpu_reset(cpu_reset),
        .load_done(load_done), .word_count(word_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_cnt   = 0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endtask

    // Takes 4 time units: status checks, then a read sweep over every address.
    task automatic check_all(input string tag);
        chk({tag, ".in_ready"},   32'(in_ready),   32'(m_phase == 1));
        chk({tag, ".cpu_reset"},  32'(cpu_reset),  32'(m_phase != 2));
        chk({tag, ".load_done"},  32'(load_done),  32'(m_phase == 2));
        chk({tag, ".word_count"}, 32'(word_count), 32'(m_cnt));
        for (int a = 0; a < D; a++) begin
            rd_addr = AW'(a);
            #1;
            chk($sformatf("%s.rd_data[%0d]", tag, a), 32'(rd_data), 32'(m_mem[a]));
        end
    endtask

    // Drive one cycle of inputs, clock it, update the model, check everything.
    task automatic step(input string tag, input logic ls, input logic v, input logic [IW-1:0] d);
        load_start = ls;
        in_valid   = v;
        in_data    = d;
        if (m_phase == 1 && v && !ls) begin
            rd_addr = AW'(m_cnt);
            #1;
            chk({tag, ".old_before_edge"}, 32'(rd_data), 32'(m_mem[m_cnt]));
        end
        @(posedge clk);
        if (ls) begin
            m_phase = 1;
            m_cnt   = 0;
        end else if (m_phase == 1 && v) begin
            m_mem[m_cnt] = d;
            m_cnt++;
            if (m_cnt == D) m_phase = 2;
        end
        #1;
        check_all(tag);
        #1;
        load_start = 1'b0;
        in_valid   = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        logic [IW-1:0] prog [D];
        reset_n    = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        rd_addr    = '0;
        model_reset();

        // Reset with the clock stopped.
        #3;
        check_all("reset");
        reset_n = 1'b1;
        #2;
        clk_en = 1'b1;

        // in_valid while idle is ignored.
        step("idle_valid", 1'b0, 1'b1, 2'b11);
        step("idle_valid", 1'b0, 1'b1, 2'b10);

        // Basic load 01,11,00,00.
        prog = '{2'b01, 2'b11, 2'b00, 2'b00};
        step("basic_start", 1'b1, 1'b0, 2'b00);
        for (int i = 0; i < D; i++) step("basic_word", 1'b0, 1'b1, prog[i]);
        step("run_valid", 1'b0, 1'b1, 2'b10);

        // Gap of 3 idle cycles between words 2 and 3.
        step("gap_start", 1'b1, 1'b0, 2'b00);
        step("gap_word", 1'b0, 1'b1, 2'(2'b01));
        step("gap_word", 1'b0, 1'b1, 2'(2'b11));
        for (int i = 0; i < 3; i++) step("gap_idle", 1'b0, 1'b0, 2'($urandom_range(3)));
        step("gap_word", 1'b0, 1'b1, 2'b00);
        step("gap_word", 1'b0, 1'b1, 2'b00);

        // Restart mid-load; the word riding with load_start is discarded.
        step("rst_start", 1'b1, 1'b0, 2'b00);
        step("rst_word", 1'b0, 1'b1, 2'b10);
        step("rst_word", 1'b0, 1'b1, 2'b10);
        step("rst_restart", 1'b1, 1'b1, 2'b11);
        for (int i = 0; i < D; i++) step("rst_word", 1'b0, 1'b1, 2'(i));

        // Reload from RUN: old contents stay visible until overwritten.
        step("reload_start", 1'b1, 1'b0, 2'b00);
        step("reload_word", 1'b0, 1'b1, 2'($urandom_range(3)));
        for (int i = 1; i < D; i++) step("reload_word", 1'b0, 1'b1, 2'($urandom_range(3)));

        // Async reset after two accepted words.
        step("ar_start", 1'b1, 1'b0, 2'b00);
        step("ar_word", 1'b0, 1'b1, 2'b11);
        step("ar_word", 1'b0, 1'b1, 2'b10);
        async_reset("async_reset");
        step("ar_after", 1'b0, 1'b1, 2'b01);

        // Random traffic.
        for (int n = 0; n < 300; n++)
            step("rand", logic'($urandom_range(15) == 0), logic'($urandom_range(1)),
                 2'($urandom_range(3)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Write-side companion to the 2-bit CPU's instruction memory. It owns the instruction store and accepts a program as a stream of instruction words over a valid/ready handshake. It serves the CPU's combinational fetch port and holds the CPU in reset until a complete program has been written. The CPU then runs programs loaded at run time instead of contents fixed at elaboration.

## Interface
- INSTR_WIDTH, 2, bits per instruction word ({opcode, data})
- DEPTH, 4, number of instruction words; must be a power of two, minimum 2
- ADDR_WIDTH, 2, log2(DEPTH); width of the read address and the write pointer
- clk  input  1  single clock; all state updates on rising edge
- reset_n  input  1  asynchronous, active-low reset; clears all state and memory
- load_start  input  1  one-cycle request to begin (or restart) a program load
- in_valid  input  1  in_data holds a valid instruction word
- in_data  input  INSTR_WIDTH  instruction word; written at the current write pointer
- in_ready  output  1  loader can accept a word this cycle
- rd_addr  input  ADDR_WIDTH  CPU fetch address (CPU pc)
- rd_data  output  INSTR_WIDTH  instruction at rd_addr, combinational
- cpu_reset  output  1  active-high hold-in-reset for the CPU
- load_done  output  1  a complete program is resident and the CPU is released
- word_count  output  ADDR_WIDTH+1  number of words accepted in the current load

## Operation
- States: IDLE, LOAD, RUN; encoded in registers; reset state is IDLE.
- In IDLE: in_ready=0, cpu_reset=1, load_done=0. Exit only on load_start -> LOAD.
- In LOAD: in_ready=1, cpu_reset=1, load_done=0.
  - A word is accepted when in_valid && in_ready: mem[wr_ptr] <= in_data, wr_ptr+1, word_count+1.
  - The DEPTH-th accepted word moves the block to RUN on the same edge.
- In RUN: in_ready=0, cpu_reset=0, load_done=1. Remain in RUN until load_start.
- load_start in any state, including LOAD: next state LOAD, wr_ptr=0, word_count=0.
  - load_start has priority over a simultaneous accept; that word is discarded and memory is not written.
- Memory is not cleared by load_start. Unwritten entries keep their prior contents.
- in_valid outside LOAD is ignored; no write, no counter change.
- wr_ptr is ADDR_WIDTH bits and wraps at DEPTH. No wrap is reachable, because LOAD exits at DEPTH words.
- word_count saturates at DEPTH (value 4 for DEPTH=4). In IDLE it reads 0.
- rd_data = mem[rd_addr] at all times, in every state.
- reset_n low: state=IDLE, wr_ptr=0, word_count=0, every mem entry=0 (the {LOAD,0} NOP). This is immediate and independent of clk.

## Timing
- Reset values: in_ready=0, cpu_reset=1, load_done=0, word_count=0, rd_data=0.
- cpu_reset is a registered state decode, so it never glitches. It drops one edge after the last word is accepted.
- load_start at edge N: in_ready=1 and cpu_reset=1 after edge N.
- Fastest full load is DEPTH+1 cycles from load_start to load_done: one cycle for load_start, then one word per cycle.
- Write then read of the same address in the same cycle: rd_data shows the old value until the edge, and the new value after it.
- in_ready depends only on state, never on in_valid, so there is no combinational loop with the source.
- in_valid may be dropped or held low for any number of cycles mid-load; the loader waits in LOAD indefinitely.
- reset_n asserted mid-load aborts the load; memory is zeroed and the CPU stays held.
- reset_n deassertion is synchronous to clk at the system level.

## Test plan
- Reset: assert reset_n=0 with clk stopped -> in_ready=0, cpu_reset=1, load_done=0, word_count=0, rd_data=00 for rd_addr 0..3.
- Basic load:
  - Stimulus: load_start, then words 01,11,00,00 on consecutive cycles.
  - Response: load_done=1 and cpu_reset=0 one edge after the 4th word; rd_data at addr 0..3 = 01,11,00,00.
  - With the CPU attached, register_A = 1 then 2.
- Backpressure gaps: same program with in_valid low for 3 cycles between words 2 and 3 -> no extra writes, word_count holds at 2 during the gap, final contents match.
- Restart mid-load:
  - Stimulus: load 10,10, then load_start asserted together with in_valid carrying 11; then load 00,01,10,11.
  - Response: 11 discarded, word_count returns to 0, final contents 00,01,10,11.
- Reload from RUN: load_start while load_done=1 -> cpu_reset=1 and load_done=0 after the next edge. Old contents stay visible on rd_data until overwritten.
- Async reset mid-load: reset_n=0 between clk edges after 2 words are accepted -> outputs reach their reset values immediately, rd_data=00 at all addresses, state IDLE.
